// File: rtl/xnor_sync_detector.sv
// xnor_sync_detector
// Serial sync-word correlator with a hunt/verify/lock frame synchroniser.
// A sliding window of the newest PAT_W bits is compared against PATTERN
// by XNOR agreement. A window with at most MAX_ERR disagreeing bits counts
// as a match. A flywheel bit counter tracks where the next sync word
// should end, so the FSM only has to check one position per frame.
//
// Handshake: in_valid is a one-way strobe and there is no ready signal.
// The block accepts in_bit on every rising edge where in_valid=1. Every
// piece of state, including the window, the counters and the FSM,
// advances only on those edges. On edges where in_valid=0, err_cnt holds
// and the match and frame_start pulses are forced low.
module xnor_sync_detector #(
   parameter int               PAT_W      = 16,
   parameter logic [PAT_W-1:0] PATTERN    = 16'hA5C3,
   parameter int               MAX_ERR    = 1,
   parameter int               FRAME_LEN  = 64,
   parameter int               LOCK_CNT   = 2,
   parameter int               UNLOCK_CNT = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_bit,
   output logic [$clog2(PAT_W+1)-1:0] err_cnt,
   output logic                       match,
   output logic                       locked,
   output logic                       frame_start,
   output logic [1:0]                 state
);

   localparam int EW = $clog2(PAT_W + 1);
   localparam int PW = $clog2(FRAME_LEN);
   localparam int HW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCK   = 2'd2
   } state_t;

   // Only the previous PAT_W-1 bits are stored. The incoming bit completes
   // the PAT_W-bit window, so the oldest bit is never needed again.
   logic [PAT_W-2:0] hist_q;
   logic [EW-1:0]    fill_q;
   logic [PW-1:0]    pos_q;
   logic [HW-1:0]    hits_q;
   logic [MW-1:0]    misses_q;
   state_t           state_q;
   logic [EW-1:0]    err_q;
   logic             match_q;
   logic             fs_q;
   logic             locked_q;

   logic [PAT_W-1:0] win_next;
   logic [PAT_W-1:0] agree;
   logic [EW-1:0]    agree_cnt;
   logic [EW-1:0]    mism;
   logic [EW-1:0]    fill_n;
   logic             full_now;
   logic             hit_now;
   logic             at_exp;

   state_t           state_n;
   logic [PW-1:0]    pos_n;
   logic [HW-1:0]    hits_n;
   logic [MW-1:0]    misses_n;
   logic             fs_n;

   // Build the window, count the agreeing bits and derive the mismatch count.
   always_comb begin
      win_next  = {hist_q, in_bit};
      agree     = ~(win_next ^ PATTERN);
      agree_cnt = '0;
      for (int i = 0; i < PAT_W; i++) begin
         agree_cnt = agree_cnt + EW'(agree[i]);
      end
      mism     = EW'(PAT_W) - agree_cnt;
      // The window counts as full once this bit is the PAT_W-th accepted bit.
      full_now = (32'(fill_q) + 1) >= PAT_W;
      fill_n   = (32'(fill_q) == PAT_W) ? fill_q : fill_q + EW'(1);
      hit_now  = full_now && (32'(mism) <= MAX_ERR);
      at_exp   = (32'(pos_q) == (FRAME_LEN - 1));
   end

   // Next-state logic for the hunt/verify/lock FSM and the flywheel counter.
   always_comb begin
      state_n  = state_q;
      hits_n   = hits_q;
      misses_n = misses_q;
      fs_n     = 1'b0;
      pos_n    = at_exp ? '0 : pos_q + PW'(1);
      if (in_valid) begin
         case (state_q)
            S_HUNT: begin
               if (hit_now) begin
                  pos_n = '0;
                  if (LOCK_CNT == 1) begin
                     // A single hit is enough, so lock straight away.
                     // The frame starts on this bit.
                     state_n  = S_LOCK;
                     hits_n   = HW'(1);
                     misses_n = '0;
                     fs_n     = 1'b1;
                  end else begin
                     state_n = S_VERIFY;
                     hits_n  = HW'(1);
                  end
               end
            end
            S_VERIFY: begin
               if (at_exp) begin
                  if (hit_now) begin
                     if ((32'(hits_q) + 1) == LOCK_CNT) begin
                        // Lock is declared on this sync word, so it already
                        // marks the start of a frame.
                        state_n  = S_LOCK;
                        misses_n = '0;
                        fs_n     = 1'b1;
                     end else begin
                        hits_n = hits_q + HW'(1);
                     end
                  end else begin
                     state_n = S_HUNT;
                     hits_n  = '0;
                  end
               end
            end
            S_LOCK: begin
               if (at_exp) begin
                  // Flywheel: mark the frame even if the sync word was damaged.
                  fs_n = 1'b1;
                  if (hit_now) begin
                     misses_n = '0;
                  end else if ((32'(misses_q) + 1) == UNLOCK_CNT) begin
                     state_n  = S_HUNT;
                     misses_n = '0;
                     hits_n   = '0;
                  end else begin
                     misses_n = misses_q + MW'(1);
                  end
               end
            end
            default: begin
               state_n = S_HUNT;
            end
         endcase
      end
   end

   // Window, fill, flywheel and FSM registers. All of them advance only on accepted bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q   <= '0;
         fill_q   <= '0;
         pos_q    <= '0;
         hits_q   <= '0;
         misses_q <= '0;
         state_q  <= S_HUNT;
         locked_q <= 1'b0;
      end else if (in_valid) begin
         hist_q   <= win_next[PAT_W-2:0];
         fill_q   <= fill_n;
         pos_q    <= pos_n;
         hits_q   <= hits_n;
         misses_q <= misses_n;
         state_q  <= state_n;
         locked_q <= (state_n == S_LOCK);
      end
   end

   // Registered outputs: err_cnt holds between accepted bits and both pulses last one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q   <= '0;
         match_q <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         match_q <= 1'b0;
         fs_q    <= 1'b0;
         if (in_valid) begin
            err_q   <= mism;
            match_q <= hit_now;
            fs_q    <= fs_n;
         end
      end
   end

   assign err_cnt     = err_q;
   assign match       = match_q;
   assign locked      = locked_q;
   assign frame_start = fs_q;
   assign state       = state_q;

endmodule

// File: tb/tb_xnor_sync_detector.sv
// tb_xnor_sync_detector
// Directed bench for xnor_sync_detector with the default parameters:
// a 16-bit pattern 0xA5C3, MAX_ERR=1, 64-bit frames, LOCK_CNT=2 and
// UNLOCK_CNT=3. Payload bits are zeros. A window holding zeros plus part
// of the sync word differs from 0xA5C3 in many bits, so the payload never
// produces a match.
module tb_xnor_sync_detector;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic [4:0] err_cnt;
   logic       match;
   logic       locked;
   logic       frame_start;
   logic [1:0] state;

   int   n_vec;
   int   n_err;
   logic toggle;

   xnor_sync_detector dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .err_cnt     (err_cnt),
      .match       (match),
      .locked      (locked),
      .frame_start (frame_start),
      .state       (state)
   );

   // Clock and initial input values.
   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      toggle   = 1'b0;
      n_vec    = 0;
      n_err    = 0;
   end

   always #5 clk = ~clk;

   // One comparison: observed value against the expected value.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply reset for one clock, optionally with a valid bit on the same edge, and check the cleared outputs.
   task automatic apply_reset(input logic with_bit);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = with_bit;
      in_bit   = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_err_cnt", err_cnt, 5'd0);
      chk("rst_match", match, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_frame_start", frame_start, 1'b0);
      chk("rst_state", state, 2'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   // Run one cycle with in_valid low. Both pulses must be low and err_cnt must hold.
   task automatic idle_cycle(input logic [4:0] exp_err);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_match", match, 1'b0);
      chk("idle_frame_start", frame_start, 1'b0);
      chk("idle_err_hold", err_cnt, exp_err);
   endtask

   // Drive one valid bit. In toggle mode an idle cycle comes first.
   task automatic send_bit(input logic b);
      if (toggle) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
         #1;
         chk("gap_match", match, 1'b0);
         chk("gap_frame_start", frame_start, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = b;
      @(posedge clk);
      #1;
   endtask

   // Send gap zero bits, then a 16-bit word MSB-first, and check the outputs after the word's last bit.
   task automatic send_frame(input logic [15:0] w, input int gap, input logic exp_fs,
                             input logic [1:0] exp_st, input logic [4:0] exp_err);
      for (int i = 0; i < gap; i++) begin
         send_bit(1'b0);
         chk("payload_fs", frame_start, 1'b0);
      end
      for (int i = 15; i >= 0; i--) begin
         send_bit(w[i]);
         if (i != 0) chk("sync_body_fs", frame_start, 1'b0);
      end
      chk("sync_err_cnt", err_cnt, exp_err);
      chk("sync_match", match, (exp_err <= 5'd1));
      chk("sync_frame_start", frame_start, exp_fs);
      chk("sync_state", state, exp_st);
      chk("sync_locked", locked, (exp_st == 2'd2));
   endtask

   // Directed sequence.
   initial begin
      logic [15:0] pat;
      pat = 16'hA5C3;

      // 1: the first sync word after reset gives a match with no errors and moves the FSM to VERIFY.
      apply_reset(1'b0);
      send_frame(16'hA5C3, 0, 1'b0, 2'd1, 5'd0);
      idle_cycle(5'd0);

      // 2: one error still matches, two errors do not.
      send_frame(16'hA5C2, 0, 1'b0, 2'd1, 5'd1);
      send_frame(16'hA5C0, 0, 1'b0, 2'd1, 5'd2);

      // 3: the second on-time sync locks, and frame_start then pulses every 64 bits.
      apply_reset(1'b0);
      send_frame(16'hA5C3, 10, 1'b0, 2'd1, 5'd0);
      send_frame(16'hA5C3, 48, 1'b1, 2'd2, 5'd0);
      send_frame(16'hA5C3, 48, 1'b1, 2'd2, 5'd0);

      // 4: two bad syncs keep lock and one good sync clears the misses. Three bad syncs drop lock.
      send_frame(16'hA5C4, 48, 1'b1, 2'd2, 5'd3);
      send_frame(16'hA5C4, 48, 1'b1, 2'd2, 5'd3);
      send_frame(16'hA5C3, 48, 1'b1, 2'd2, 5'd0);
      send_frame(16'hA5C4, 48, 1'b1, 2'd2, 5'd3);
      send_frame(16'hA5C4, 48, 1'b1, 2'd2, 5'd3);
      send_frame(16'hA5C4, 48, 1'b1, 2'd0, 5'd3);

      // 5: a spurious sync 20 bits into VERIFY is ignored, and a miss at the expected bit returns to HUNT.
      apply_reset(1'b0);
      send_frame(16'hA5C3, 10, 1'b0, 2'd1, 5'd0);
      send_frame(16'hA5C3, 4, 1'b0, 2'd1, 5'd0);
      for (int i = 0; i < 43; i++) send_bit(1'b0);
      chk("verify_before_expected", state, 2'd1);
      send_bit(1'b0);
      chk("verify_miss_state", state, 2'd0);
      chk("verify_miss_locked", locked, 1'b0);

      // 6: with in_valid toggling, the same stream gives the same lock sequence counted in valid bits.
      toggle = 1'b1;
      apply_reset(1'b0);
      send_frame(16'hA5C3, 10, 1'b0, 2'd1, 5'd0);
      send_frame(16'hA5C3, 48, 1'b1, 2'd2, 5'd0);
      send_frame(16'hA5C3, 48, 1'b1, 2'd2, 5'd0);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      chk("toggle_locked_midframe", locked, 1'b1);
      // Reset mid-frame with a valid bit on the same edge. Reset wins.
      toggle = 1'b0;
      apply_reset(1'b1);
      // Fifteen bits leave the window at 0x25C3, one bit from the pattern, but the window is not yet full.
      for (int i = 14; i >= 0; i--) begin
         send_bit(pat[i]);
         chk("refill_no_match", match, 1'b0);
      end
      chk("refill_err_cnt", err_cnt, 5'd1);
      chk("refill_state", state, 2'd0);
      // Once the window has refilled, a full sync word matches again.
      send_frame(16'hA5C3, 0, 1'b0, 2'd1, 5'd0);

      @(negedge clk);
      in_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xnor_sync_detector.md
Name: xnor_sync_detector

Overview:
- Serial sync-word correlator, downstream of the XNOR gate primitive. Takes a bit stream, compares a sliding window against a fixed sync pattern using bitwise XNOR agreement and a popcount, and tolerates up to MAX_ERR mismatched bits.
- A hunt/verify/lock state machine declares frame lock and provides a flywheel frame-start marker to the downstream deframer.

Parameters:
- PAT_W, 16: sync pattern width in bits (4..32).
- PATTERN, 16'hA5C3: sync word; MSB is received first.
- MAX_ERR, 1: maximum mismatched bits still accepted as a match (0..PAT_W-1).
- FRAME_LEN, 64: bits from one sync word's last bit to the next sync word's last bit (FRAME_LEN ≥ PAT_W).
- LOCK_CNT, 2: consecutive on-time matches in VERIFY required to enter LOCK (≥1).
- UNLOCK_CNT, 3: consecutive on-time misses in LOCK that force return to HUNT (≥1).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_bit is valid this cycle; all state advances only when in_valid=1.
- in_bit, input, 1: serial data bit.
- err_cnt, output, $clog2(PAT_W+1): mismatch count of the current window.
- match, output, 1: one-cycle pulse; window is full and err_cnt ≤ MAX_ERR.
- locked, output, 1: high while the FSM is in LOCK.
- frame_start, output, 1: one-cycle pulse at each expected sync position while in LOCK (flywheel).
- state, output, 2: 0=HUNT, 1=VERIFY, 2=LOCK.

Behaviour:
- Reset: shift register 0, fill counter 0, bit_pos 0, hit/miss counters 0, state HUNT. Outputs: err_cnt=0, match=0, locked=0, frame_start=0.
- Shift register: on in_valid, win_next = {win[PAT_W-2:0], in_bit}. The newest bit is the LSB.
- Compare:
  - agree = ~(win_next ^ PATTERN).
  - mismatch = PAT_W − popcount(agree).
  - err_cnt and match are registered, so they are valid the cycle after the in_valid edge that shifted in the pattern's last bit. Latency is 1 cycle.
- Fill:
  - match is suppressed until PAT_W bits have been accepted since reset.
  - err_cnt updates regardless of fill.
  - The fill counter saturates at PAT_W.
- No in_valid: err_cnt holds its value; match and frame_start are 0 that cycle.
- bit_pos:
  - Counts 0..FRAME_LEN−1 on in_valid.
  - Set to 0 on the bit that produced an accepted sync.
  - The expected sync position is the in_valid bit where bit_pos == FRAME_LEN−1; that bit wraps bit_pos to 0.
- FSM, evaluated on the same in_valid bit as the compare:
  - HUNT: any match → VERIFY, hits=1, bit_pos=0. If LOCK_CNT=1, go directly to LOCK instead.
  - VERIFY, at the expected position:
    - Match: hits+1. If hits+1 == LOCK_CNT → LOCK, misses=0.
    - Miss → HUNT.
  - VERIFY, off the expected position: matches are ignored.
  - LOCK, at the expected position:
    - frame_start=1, whether or not the sync word matched.
    - Match → misses=0.
    - Miss → misses+1. If misses+1 == UNLOCK_CNT → HUNT and locked drops the next cycle.
  - LOCK, off the expected position: matches are ignored; bit_pos keeps free-running.
  - A miss-triggered return to HUNT does not re-hunt on that same bit; hunting resumes from the next in_valid bit.
- locked and state are registered and reflect the FSM after the edge.
- frame_start asserts in the same cycle as match for that bit.
- Simultaneous rst and in_valid: rst wins and the bit is discarded.
- Reset mid-frame: all counters and the window clear. A full re-fill of PAT_W bits is required before the next match.
- Error-count width: popcount is computed at $clog2(PAT_W+1) bits, with no overflow.

Test Plan:
1. Reset, then feed 16 bits of 0xA5C3 MSB-first, with in_valid held high → after the 16th bit: err_cnt=0, match pulses 1 cycle, state=1 (VERIFY).
2. Window 0xA5C2 (1 error) → err_cnt=1, match=1. Window 0xA5C0 (2 errors) → err_cnt=2, match=0.
3. Send the sync word every 64 bits with random payload (payload never matches) → state VERIFY after the 1st sync, LOCK after the 2nd. frame_start pulses every 64 valid bits from the 2nd sync on.
4. While locked, corrupt 2 consecutive sync words (3 errors each) → frame_start still pulses at both positions and locked stays 1. Send the next sync intact → misses clear. Then corrupt 3 consecutive → after the 3rd, locked=0 and state=0.
5. In VERIFY, send a spurious valid sync 20 bits after the first, then none at bit 64 → the spurious match is ignored, and the FSM returns to HUNT at the expected position.
6. Toggle in_valid 0/1 every cycle while sending the stream of scenario 3 → identical lock and frame_start sequence counted in valid bits. Assert rst mid-frame → all outputs 0 the next cycle, and no match for 15 following bits even if the pattern is present.
